// File: rtl/udp_tx_sched_pkg.sv
// Shared types and helpers for the UDP transmit scheduler.
// Holds the FSM state type, nibble constants and the round-robin pick function.
package udp_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_START,
        WAIT_DONE
    } sched_state_t;

    localparam int NIBBLES_PER_BYTE = 2;
    localparam int MAX_REQ          = 8;

    // First set request at or after ptr, wrapping modulo n_req; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int ptr,
                                                   input int n_req);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        logic [2:0]         sel;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n_req) idx = idx - n_req;
            sel = 3'(idx);
            if (k < n_req && !found && req[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: one-hot winner and its index from req and rr_ptr.
module rr_arbiter
    import udp_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] pick_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick_ext;

    // NOTE: every output gets a default before any conditional write so no latch is inferred.
    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        pick_ext             = rr_pick(req_ext, int'(rr_ptr), N_REQ);
        pick                 = pick_ext[N_REQ-1:0];
        pick_idx             = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick_ext[i]) pick_idx = PTR_W'(i);
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin packet scheduler feeding the ethernet_udp_transmit nibble FIFO.
// Optional per-requester statistics are enabled with `define UDP_TX_SCHED_STATS_EN.
module udp_tx_scheduler
    import udp_tx_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int PAYLOAD_BYTES = 256,
    parameter int BUSY_TIMEOUT  = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   src_data,
    input  logic [N_REQ-1:0]     src_valid,
    output logic [N_REQ-1:0]     src_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    input  logic                 eth_ready,
    input  logic                 mac_busy,
    input  logic                 wr_full,
    output logic                 wr_en,
    output logic [3:0]           wr_data,
    output logic                 timeout_err
`ifdef UDP_TX_SCHED_STATS_EN
    ,
    output logic [16*N_REQ-1:0]  pkt_count,
    output logic [15:0]          timeout_count
`endif
);

    localparam int PTR_W = (N_REQ > 1)         ? $clog2(N_REQ)         : 1;
    localparam int CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TMO_W = (BUSY_TIMEOUT > 1)  ? $clog2(BUSY_TIMEOUT)  : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic             PHASE_HI  = 1'b0;
    localparam logic             PHASE_LO  = 1'(NIBBLES_PER_BYTE - 1);

    sched_state_t     state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gidx;
    logic [CNT_W-1:0] byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             phase;
    logic [7:0]       byte_q;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       cur_byte;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign cur_byte = src_data[8*gidx +: 8];
    assign next_ptr = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gidx        <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            phase       <= PHASE_HI;
            byte_q      <= '0;
            grant       <= '0;
            src_ready   <= '0;
            done        <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            src_ready   <= '0;
            done        <= '0;
            wr_en       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (eth_ready && |req) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        phase <= PHASE_HI;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (phase == PHASE_HI) begin
                        if (src_valid[gidx] && !wr_full) begin
                            src_ready <= grant;
                            byte_q    <= cur_byte;
                            wr_en     <= 1'b1;
                            wr_data   <= cur_byte[7:4];
                            phase     <= PHASE_LO;
                        end
                    end else if (!wr_full) begin
                        wr_en   <= 1'b1;
                        wr_data <= byte_q[3:0];
                        phase   <= PHASE_HI;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            state    <= WAIT_START;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WAIT_START: begin
                    // A MAC that never starts the frame must not wedge the shared port.
                    if (mac_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= grant;
                        rr_ptr      <= next_ptr;
                        grant       <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!mac_busy) begin
                        done   <= grant;
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_TX_SCHED_STATS_EN
    // Counts follow the registered done/timeout pulses; timed-out packets are not completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count     <= '0;
            timeout_count <= '0;
        end else if (timeout_err) begin
            timeout_count <= timeout_count + 16'd1;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (done[i]) pkt_count[16*i +: 16] <= pkt_count[16*i +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Shares one ethernet_udp_transmit write port between N_REQ payload sources.
- Grants one requester per packet, round-robin; streams exactly PAYLOAD_BYTES bytes as nibbles (high nibble first) into the MAC FIFO.
- Waits for the MAC to finish sending the frame before granting the next packet.
- Sits between the payload generators and ethernet_udp_transmit, in the clk (100 MHz) domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PAYLOAD_BYTES, 256, bytes per packet; must equal MIN_DATA_BYTES of the MAC.
- BUSY_TIMEOUT, 1_000_000, clk cycles to wait for mac_busy to rise after the last nibble.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  requester i has a packet pending (level).
- src_data  in  8*N_REQ  byte from requester i, at bits [8i+:8].
- src_valid  in  N_REQ  src_data[i] valid.
- src_ready  out  N_REQ  one-cycle accept strobe to the granted requester.
- grant  out  N_REQ  one-hot owner of the current packet; 0 when idle.
- done  out  N_REQ  one-cycle pulse to the owner at packet end.
- eth_ready  in  1  MAC power-up complete.
- mac_busy  in  1  MAC is transmitting a frame.
- wr_full  in  1  MAC FIFO full.
- wr_en  out  1  nibble write strobe.
- wr_data  out  4  nibble.
- timeout_err  out  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; byte_cnt=0; phase=0.
- All outputs are registered.
- IDLE:
  - If eth_ready && |req, select the first i with req[i] set, searching from rr_ptr upward and wrapping modulo N_REQ.
  - Set grant=onehot(i) next cycle and go to STREAM.
  - Otherwise hold.
- STREAM, phase 0:
  - If src_valid[g] && !wr_full: pulse src_ready[g], latch the byte, wr_en=1, wr_data=byte[7:4], phase<=1.
  - Otherwise wr_en=0 (stall).
- STREAM, phase 1:
  - If !wr_full: wr_en=1, wr_data=byte[3:0], phase<=0, byte_cnt++.
  - Otherwise wr_en=0 and hold.
  - When the nibble written is the last one (byte_cnt==PAYLOAD_BYTES-1), go to WAIT_START and clear byte_cnt and the timeout counter.
- Throughput: at most one nibble per cycle; an unstalled packet takes 2*PAYLOAD_BYTES cycles.
- WAIT_START:
  - When mac_busy==1, go to WAIT_DONE.
  - Otherwise increment the timeout counter. At BUSY_TIMEOUT-1: pulse timeout_err and done[g], update rr_ptr, go to IDLE.
- WAIT_DONE: when mac_busy==0, pulse done[g], set rr_ptr<=(g+1)%N_REQ, clear grant, go to IDLE.
- Minimum gap from done to the next grant: 1 cycle, because the IDLE decision is registered.
- req deasserted mid-packet: ignored; the packet still completes with PAYLOAD_BYTES bytes.
- eth_ready is sampled only in IDLE; a drop mid-packet does not abort the packet.
- src_valid[j] and req[j] for j != g are ignored; src_ready[j] stays 0.
- wr_full and src_valid low together: stall with no nibble lost or duplicated.
- Reset mid-operation: immediate return to reset values; the partial packet is discarded (the MAC must be reset too).
- Counters are sized $clog2 of their limit, minimum 1 bit.

Optional Feature:
- UDP_TX_SCHED_STATS_EN defined:
  - Adds output pkt_count, 16*N_REQ bits.
  - Per-requester wrapping count of completed packets, incremented on done[i], excluding timeouts.
  - Adds output timeout_count, 16 bits, wrapping.
  - Both reset to 0.
- Not defined: both ports and their counters are absent.

Decomposition:
- Package udp_tx_sched_pkg holds:
  - sched_state_t enum: IDLE, STREAM, WAIT_START, WAIT_DONE.
  - NIBBLES_PER_BYTE=2.
  - Function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, rr_arbiter: combinational round-robin pick from req and rr_ptr.
- The FSM, counters and nibble mux stay in udp_tx_scheduler.

Test Plan:
- eth_ready=0, req=4'b0001 for 1000 cycles -> grant stays 0 and wr_en never asserts. Raise eth_ready -> grant=0001 within 2 cycles.
- Single requester, bytes 0x00..0xFF always valid, PAYLOAD_BYTES=256, wr_full=0 -> exactly 512 consecutive wr_en cycles, data 0,0,0,1,...,F,F. Pulse mac_busy for 100 cycles -> done[0] pulses one cycle after mac_busy falls.
- req=4'b1111 held, MAC model completes each frame -> grant order 0001,0010,0100,1000,0001. Each requester gets exactly 256 src_ready pulses per grant.
- Random wr_full 30% and src_valid 50% -> captured nibble stream equals the source bytes exactly, and the nibble count is 512.
- mac_busy never rises, BUSY_TIMEOUT=1000 -> timeout_err pulses once 1000 cycles after the last nibble, together with done[g]. Next grant goes to g+1.
- Assert reset at nibble 100 -> all outputs 0 in the same cycle. After release, the next packet starts at byte 0 from requester 0.
